// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : RISC-V instruction-fetch stage. Owns PCF, drives a
//               single-outstanding request/response instruction memory port
//               and loads the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        discard_q, discard_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic        validd_q, validd_d;

  logic [31:0] pc_plus4;
  logic        req_c;
  logic        load_en;
  logic [31:0] load_instr;

  // Wraps modulo 2^32 naturally through the 32-bit result width.
  assign pc_plus4 = pcf_q + 32'd4;

  // Fetch FSM: request issue, response steering, PC update and redirect.
  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    discard_d  = discard_q;
    hold_d     = hold_q;
    req_c      = 1'b0;
    imem_addr  = pcf_q;
    load_en    = 1'b0;
    load_instr = hold_q;

    case (state_q)
      S_REQ: begin
        req_c = ~StallF & ~PCSrcE;
        if (req_c && imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (discard_q || PCSrcE) begin
            // Stale or redirected-away response: drop it.
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (StallD) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            // Load and immediately chain the next sequential request.
            load_en    = 1'b1;
            load_instr = imem_rdata;
            pcf_d      = pc_plus4;
            req_c      = ~StallF;
            imem_addr  = pc_plus4;
            state_d    = (req_c && imem_ready) ? S_WAIT : S_REQ;
          end
        end else if (PCSrcE) begin
          // Response still in flight; remember to throw it away.
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          state_d = S_REQ;
        end else if (!StallD) begin
          load_en    = 1'b1;
          load_instr = hold_q;
          pcf_d      = pc_plus4;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides any sequential PC update, even under StallF.
    if (PCSrcE) pcf_d = PCTargetE;
  end

  assign imem_req = req_c & ~rst;

  // IF/ID next value: flush > stall > load > bubble.
  always_comb begin
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    if (FlushD || PCSrcE) begin
      instr_d  = NOP_INSTR;
      validd_d = 1'b0;
    end else if (StallD) begin
      validd_d = validd_q;
    end else if (load_en) begin
      instr_d    = load_instr;
      pcd_d      = pcf_q;
      pcplus4d_d = pc_plus4;
      validd_d   = 1'b1;
    end else begin
      instr_d  = NOP_INSTR;
      validd_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pcf_q      <= RESET_PC;
      discard_q  <= 1'b0;
      hold_q     <= NOP_INSTR;
      instr_q    <= NOP_INSTR;
      pcd_q      <= 32'd0;
      pcplus4d_q <= 32'd0;
      validd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4d_q;
  assign ValidD   = validd_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage: cycle vector table
//               plus a zero-wait streaming memory sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A   = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  always #5 clk = ~clk;

  // ctl = {rst, StallF, StallD, FlushD, PCSrcE}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] einstr;
    logic [31:0] epcd;
    logic [31:0] epcp4;
    logic        evd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] c, input logic [31:0] tgt, input logic rdy,
                     input logic rv, input logic [31:0] rd, input logic er,
                     input logic [31:0] ea, input logic [31:0] ei,
                     input logic [31:0] ep, input logic [31:0] ep4, input logic ev);
    vec_t v;
    v.ctl = c; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.ereq = er; v.eaddr = ea; v.einstr = ei; v.epcd = ep; v.epcp4 = ep4; v.evd = ev;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] c, input logic [31:0] tgt, input logic rdy,
                       input logic rv, input logic [31:0] rd);
    {rst, StallF, StallD, FlushD, PCSrcE} = c;
    PCTargetE   = tgt;
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rd;
  endtask

  initial begin
    int          pending;
    logic [31:0] paddr;
    int          nreq;
    int          ninstr;
    logic        hs;

    drive(5'b10000, 32'd0, 1'b0, 1'b0, 32'd0);

    //   ctl      tgt            rdy rv rd            req addr           instr          pcd            pcp4           vd
    // Reset
    add(5'b10000, 32'h0,         0, 0, 32'h0,        0, 32'h0,         NOP,           32'h0,         32'h0,         0); // 0
    add(5'b10000, 32'h0,         0, 0, 32'h0,        0, 32'h0,         NOP,           32'h0,         32'h0,         0); // 1
    // Zero-wait stream
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h0,         NOP,           32'h0,         32'h0,         0); // 2
    add(5'b00000, 32'h0,         1, 1, A|32'h0,      1, 32'h4,         A|32'h0,       32'h0,         32'h4,         1); // 3
    add(5'b00000, 32'h0,         1, 1, A|32'h4,      1, 32'h8,         A|32'h4,       32'h4,         32'h8,         1); // 4
    add(5'b00000, 32'h0,         1, 1, A|32'h8,      1, 32'hC,         A|32'h8,       32'h8,         32'hC,         1); // 5
    add(5'b00000, 32'h0,         0, 1, A|32'hC,      1, 32'h10,        A|32'hC,       32'hC,         32'h10,        1); // 6
    // 3-cycle response latency
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h10,        NOP,           32'hC,         32'h10,        0); // 7
    add(5'b00000, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'hC,         32'h10,        0); // 8
    add(5'b00000, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'hC,         32'h10,        0); // 9
    add(5'b00000, 32'h0,         1, 1, A|32'h10,     1, 32'h14,        A|32'h10,      32'h10,        32'h14,        1); // 10
    add(5'b00000, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'h10,        32'h14,        0); // 11
    add(5'b00000, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'h10,        32'h14,        0); // 12
    add(5'b00000, 32'h0,         0, 1, A|32'h14,     1, 32'h18,        A|32'h14,      32'h14,        32'h18,        1); // 13
    // StallD while the response arrives
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h18,        NOP,           32'h14,        32'h18,        0); // 14
    add(5'b00100, 32'h0,         1, 1, A|32'h18,     0, 32'h0,         NOP,           32'h14,        32'h18,        0); // 15
    add(5'b00100, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'h14,        32'h18,        0); // 16
    add(5'b00100, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'h14,        32'h18,        0); // 17
    add(5'b00000, 32'h0,         1, 0, 32'h0,        0, 32'h0,         A|32'h18,      32'h18,        32'h1C,        1); // 18
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h1C,        NOP,           32'h18,        32'h1C,        0); // 19
    // Redirect while a request is in flight
    add(5'b00001, 32'h100,       1, 0, 32'h0,        0, 32'h0,         NOP,           32'h18,        32'h1C,        0); // 20
    add(5'b00000, 32'h0,         1, 1, A|32'h1C,     0, 32'h0,         NOP,           32'h18,        32'h1C,        0); // 21
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h100,       NOP,           32'h18,        32'h1C,        0); // 22
    add(5'b00000, 32'h0,         0, 1, A|32'h100,    1, 32'h104,       A|32'h100,     32'h100,       32'h104,       1); // 23
    // FlushD with StallD, then StallF, then redirect under StallF
    add(5'b00110, 32'h0,         0, 0, 32'h0,        1, 32'h104,       NOP,           32'h100,       32'h104,       0); // 24
    add(5'b00000, 32'h0,         0, 0, 32'h0,        1, 32'h104,       NOP,           32'h100,       32'h104,       0); // 25
    add(5'b01000, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'h100,       32'h104,       0); // 26
    add(5'b01001, 32'hFFFF_FFFC, 1, 0, 32'h0,        0, 32'h0,         NOP,           32'h100,       32'h104,       0); // 27
    // PC wrap
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'hFFFF_FFFC, NOP,           32'h100,       32'h104,       0); // 28
    add(5'b00000, 32'h0,         1, 1, 32'h1234_5678, 1, 32'h0,        32'h1234_5678, 32'hFFFF_FFFC, 32'h0,         1); // 29
    // Reset mid-WAIT
    add(5'b10000, 32'h0,         1, 0, 32'h0,        0, 32'h0,         NOP,           32'h0,         32'h0,         0); // 30
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h0,         NOP,           32'h0,         32'h0,         0); // 31
    // Redirect coincident with rvalid
    add(5'b00001, 32'h200,       1, 1, 32'hDEAD_BEEF, 0, 32'h0,        NOP,           32'h0,         32'h0,         0); // 32
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h200,       NOP,           32'h0,         32'h0,         0); // 33
    // Redirect while holding a buffered word
    add(5'b00100, 32'h0,         1, 1, 32'h1111_1111, 0, 32'h0,        NOP,           32'h0,         32'h0,         0); // 34
    add(5'b00101, 32'h300,       1, 0, 32'h0,        0, 32'h0,         NOP,           32'h0,         32'h0,         0); // 35
    add(5'b00000, 32'h0,         1, 0, 32'h0,        1, 32'h300,       NOP,           32'h0,         32'h0,         0); // 36
    add(5'b00000, 32'h0,         0, 1, 32'h3333_3333, 1, 32'h304,      32'h3333_3333, 32'h300,       32'h304,       1); // 37

    // Apply each vector: combinational request checked before the edge,
    // IF/ID checked just after it.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ctl, vecs[i].tgt, vecs[i].rdy, vecs[i].rv, vecs[i].rd);
      #1;
      chk("imem_req", i, {31'd0, imem_req}, {31'd0, vecs[i].ereq});
      if (vecs[i].ereq) chk("imem_addr", i, imem_addr, vecs[i].eaddr);
      @(posedge clk);
      #1;
      chk("InstrD",   i, InstrD,   vecs[i].einstr);
      chk("PCD",      i, PCD,      vecs[i].epcd);
      chk("PCPlus4D", i, PCPlus4D, vecs[i].epcp4);
      chk("ValidD",   i, {31'd0, ValidD}, {31'd0, vecs[i].evd});
    end

    // Streaming sequence: 1-cycle memory returning addr|A000_0000.
    @(negedge clk);
    drive(5'b10000, 32'd0, 1'b1, 1'b0, 32'd0);
    pending = 0; paddr = 32'd0; nreq = 0; ninstr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(5'b00000, 32'd0, 1'b1, (pending != 0), paddr | A);
      #1;
      hs = imem_req & imem_ready;
      if (hs) begin
        chk("stream_addr", c, imem_addr, nreq * 4);
        nreq++;
      end
      pending = hs ? 1 : 0;
      paddr   = imem_addr;
      @(posedge clk);
      #1;
      if (imem_rvalid) begin
        chk("stream_instr", c, InstrD, A | (ninstr * 4));
        chk("stream_pcd",   c, PCD,    ninstr * 4);
        chk("stream_valid", c, {31'd0, ValidD}, 32'd1);
        ninstr++;
      end
    end
    chk("stream_count", 0, ninstr, 32'd9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
